// File: rtl/ldr_emu_pkg.sv
// Shared types and constants for the LDR emulator: FSM state encoding,
// mode codes and the saturating counter helper.
package ldr_emu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DAY      = 3'd1,
        ST_NIGHT    = 3'd2,
        ST_BURST_HI = 3'd3,
        ST_BURST_LO = 3'd4
    } state_t;

    localparam logic [1:0] MODE_MANUAL = 2'd0;
    localparam logic [1:0] MODE_CYCLE  = 2'd1;
    localparam logic [1:0] MODE_BURST  = 2'd2;

    localparam logic [7:0] CYCLES_MAX = 8'd255;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        sat_inc8 = (v == CYCLES_MAX) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/ldr_emulator_if.sv
// Control/status bundle between a stimulus controller (master) and the
// LDR emulator (slave).
interface ldr_emulator_if;
    logic       en;
    logic [1:0] mode;
    logic       manual_level;
    logic       start;
    logic       stop;
    logic       ldr_out;
    logic       busy;
    logic       phase_pulse;
    logic [7:0] cycles;

    modport master (
        output en, mode, manual_level, start, stop,
        input  ldr_out, busy, phase_pulse, cycles
    );

    modport slave (
        input  en, mode, manual_level, start, stop,
        output ldr_out, busy, phase_pulse, cycles
    );
endinterface

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-cycle tick every TICK_DIV enabled cycles;
// holds its count while en=0 and restarts from zero on clr.
module tick_prescaler #(
    parameter int TICK_DIV = 50
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    if (TICK_DIV < 1) begin : g_bad_div
        $error("tick_prescaler: TICK_DIV must be >= 1");
    end

    logic [CW-1:0] count_r;

    // Free-running divider, frozen while disabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= {CW{1'b0}};
        end else if (clr) begin
            count_r <= {CW{1'b0}};
        end else if (en) begin
            if (count_r == LAST) begin
                count_r <= {CW{1'b0}};
            end else begin
                count_r <= count_r + CW'(1);
            end
        end
    end

    assign tick = en && (count_r == LAST);
endmodule

// File: rtl/ldr_emulator.sv
// Programmable light-level source: manual level, continuous day/night
// cycle, or a finite burst of fast toggles, timed in prescaled ticks.
module ldr_emulator
    import ldr_emu_pkg::*;
#(
    parameter int TICK_DIV    = 50,
    parameter int CNT_W       = 16,
    parameter int DAY_LEN     = 1000,
    parameter int NIGHT_LEN   = 1000,
    parameter int BURST_LEN   = 2,
    parameter int BURST_COUNT = 4
) (
    input logic           clk,
    input logic           rst,
    ldr_emulator_if.slave bus
);
    localparam int PAIR_W = (BURST_COUNT > 1) ? $clog2(BURST_COUNT + 1) : 1;
    localparam logic [CNT_W-1:0]  DAY_LAST   = CNT_W'(DAY_LEN - 1);
    localparam logic [CNT_W-1:0]  NIGHT_LAST = CNT_W'(NIGHT_LEN - 1);
    localparam logic [CNT_W-1:0]  BURST_LAST = CNT_W'(BURST_LEN - 1);
    localparam logic [PAIR_W-1:0] PAIR_LAST  = PAIR_W'(BURST_COUNT - 1);

    if (DAY_LEN < 1 || DAY_LEN > (2**CNT_W) - 1) begin : g_bad_day
        $error("ldr_emulator: DAY_LEN out of range");
    end
    if (NIGHT_LEN < 1 || NIGHT_LEN > (2**CNT_W) - 1) begin : g_bad_night
        $error("ldr_emulator: NIGHT_LEN out of range");
    end
    if (BURST_LEN < 1 || BURST_LEN > (2**CNT_W) - 1) begin : g_bad_burst
        $error("ldr_emulator: BURST_LEN out of range");
    end
    if (BURST_COUNT < 1) begin : g_bad_count
        $error("ldr_emulator: BURST_COUNT must be >= 1");
    end

    state_t            state_r;
    logic [CNT_W-1:0]  phase_cnt_r;
    logic [PAIR_W-1:0] pair_cnt_r;
    logic              ldr_out_r;
    logic              busy_r;
    logic              phase_pulse_r;
    logic [7:0]        cycles_r;
    logic              tick_s;
    logic              start_ok_s;
    logic [CNT_W-1:0]  phase_last_s;

    // Start is honoured only from IDLE, with a runnable mode and no stop
    assign start_ok_s = bus.en && bus.start && !bus.stop && (state_r == ST_IDLE) &&
                        ((bus.mode == MODE_CYCLE) || (bus.mode == MODE_BURST));

    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (bus.en),
        .clr  (start_ok_s),
        .tick (tick_s)
    );

    // Terminal tick count of the phase currently being timed
    always_comb begin
        phase_last_s = {CNT_W{1'b0}};
        case (state_r)
            ST_DAY:      phase_last_s = DAY_LAST;
            ST_NIGHT:    phase_last_s = NIGHT_LAST;
            ST_BURST_HI: phase_last_s = BURST_LAST;
            ST_BURST_LO: phase_last_s = BURST_LAST;
            default:     phase_last_s = {CNT_W{1'b0}};
        endcase
    end

    // Phase sequencer; with en=0 everything holds and only the pulse drops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            phase_cnt_r   <= {CNT_W{1'b0}};
            pair_cnt_r    <= {PAIR_W{1'b0}};
            ldr_out_r     <= 1'b0;
            busy_r        <= 1'b0;
            phase_pulse_r <= 1'b0;
            cycles_r      <= 8'd0;
        end else if (!bus.en) begin
            phase_pulse_r <= 1'b0;
        end else begin
            phase_pulse_r <= 1'b0;
            if (state_r == ST_IDLE) begin
                ldr_out_r   <= bus.manual_level;
                phase_cnt_r <= {CNT_W{1'b0}};
                if (start_ok_s) begin
                    busy_r    <= 1'b1;
                    ldr_out_r <= 1'b1;
                    if (bus.mode == MODE_CYCLE) begin
                        state_r  <= ST_DAY;
                        cycles_r <= 8'd0;
                    end else begin
                        state_r    <= ST_BURST_HI;
                        pair_cnt_r <= {PAIR_W{1'b0}};
                    end
                end
            end else if (bus.stop) begin
                state_r     <= ST_IDLE;
                busy_r      <= 1'b0;
                ldr_out_r   <= bus.manual_level;
                phase_cnt_r <= {CNT_W{1'b0}};
                pair_cnt_r  <= {PAIR_W{1'b0}};
            end else if (tick_s) begin
                if (phase_cnt_r != phase_last_s) begin
                    phase_cnt_r <= phase_cnt_r + CNT_W'(1);
                end else begin
                    phase_cnt_r   <= {CNT_W{1'b0}};
                    phase_pulse_r <= 1'b1;
                    case (state_r)
                        ST_DAY: begin
                            state_r   <= ST_NIGHT;
                            ldr_out_r <= 1'b0;
                        end
                        ST_NIGHT: begin
                            state_r   <= ST_DAY;
                            ldr_out_r <= 1'b1;
                            cycles_r  <= sat_inc8(cycles_r);
                        end
                        ST_BURST_HI: begin
                            state_r   <= ST_BURST_LO;
                            ldr_out_r <= 1'b0;
                        end
                        ST_BURST_LO: begin
                            if (pair_cnt_r == PAIR_LAST) begin
                                state_r    <= ST_IDLE;
                                busy_r     <= 1'b0;
                                ldr_out_r  <= bus.manual_level;
                                pair_cnt_r <= {PAIR_W{1'b0}};
                            end else begin
                                state_r    <= ST_BURST_HI;
                                ldr_out_r  <= 1'b1;
                                pair_cnt_r <= pair_cnt_r + PAIR_W'(1);
                            end
                        end
                        default: begin
                            state_r       <= ST_IDLE;
                            busy_r        <= 1'b0;
                            ldr_out_r     <= bus.manual_level;
                            phase_pulse_r <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    assign bus.ldr_out     = ldr_out_r;
    assign bus.busy        = busy_r;
    assign bus.phase_pulse = phase_pulse_r;
    assign bus.cycles      = cycles_r;
endmodule

// File: tb/tb_ldr_emulator.sv
// Directed bench for ldr_emulator: an elapsed-time model predicts every output
// each cycle, and literal checks pin the key timings from hand calculation.
module tb_ldr_emulator;
    localparam int TD = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_pass = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    ldr_emulator_if bus_a ();
    ldr_emulator_if bus_b ();

    ldr_emulator #(.TICK_DIV(TD), .CNT_W(16), .DAY_LEN(3), .NIGHT_LEN(2),
                   .BURST_LEN(1), .BURST_COUNT(2))
        dut_a (.clk(clk), .rst(rst), .bus(bus_a));

    ldr_emulator #(.TICK_DIV(TD), .CNT_W(16), .DAY_LEN(1), .NIGHT_LEN(1),
                   .BURST_LEN(1), .BURST_COUNT(2))
        dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    // Model: outputs derived from enabled cycles elapsed since the start edge
    typedef struct {
        bit busy;
        bit burst;
        int elapsed;
        bit ldr;
        bit pulse;
        int cyc;
    } mdl_t;

    function automatic mdl_t mdl_zero();
        mdl_t z;
        z.busy = 0; z.burst = 0; z.elapsed = 0; z.ldr = 0; z.pulse = 0; z.cyc = 0;
        return z;
    endfunction

    function automatic mdl_t mdl_next(mdl_t m, int dl, int nl, int bl, int bc,
                                      logic en, logic [1:0] mode, logic man,
                                      logic start, logic stop);
        mdl_t n;
        int p, pos, h;
        n = m;
        n.pulse = 0;
        if (en) begin
            if (!m.busy) begin
                n.ldr = man;
                if (start && !stop && (mode == 2'd1 || mode == 2'd2)) begin
                    n.busy = 1; n.burst = (mode == 2'd2); n.elapsed = 0; n.ldr = 1;
                    if (mode == 2'd1) n.cyc = 0;
                end
            end else if (stop) begin
                n.busy = 0;
                n.ldr = man;
            end else begin
                n.elapsed = m.elapsed + 1;
                if (!m.burst) begin
                    p   = (dl + nl) * TD;
                    pos = n.elapsed % p;
                    n.ldr   = (pos < dl * TD);
                    n.pulse = (pos == dl * TD) || (pos == 0);
                    n.cyc   = (n.elapsed / p > 255) ? 255 : n.elapsed / p;
                end else begin
                    h = bl * TD;
                    if (n.elapsed == 2 * bc * h) begin
                        n.busy = 0; n.ldr = man; n.pulse = 1;
                    end else begin
                        n.ldr   = ((n.elapsed / h) % 2) == 0;
                        n.pulse = (n.elapsed % h) == 0;
                    end
                end
            end
        end
        return n;
    endfunction

    mdl_t ma, mb;

    // Advance both models on the same edges the DUTs see
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ma <= mdl_zero();
            mb <= mdl_zero();
        end else begin
            ma <= mdl_next(ma, 3, 2, 1, 2, bus_a.en, bus_a.mode, bus_a.manual_level,
                           bus_a.start, bus_a.stop);
            mb <= mdl_next(mb, 1, 1, 1, 2, bus_b.en, bus_b.mode, bus_b.manual_level,
                           bus_b.start, bus_b.stop);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Compare process, well clear of both clock edges
    always @(negedge clk) begin
        #2;
        if (!rst) begin
            chk("a_ldr_out", int'(bus_a.ldr_out), int'(ma.ldr));
            chk("a_busy", int'(bus_a.busy), int'(ma.busy));
            chk("a_phase_pulse", int'(bus_a.phase_pulse), int'(ma.pulse));
            chk("a_cycles", int'(bus_a.cycles), ma.cyc);
            chk("b_ldr_out", int'(bus_b.ldr_out), int'(mb.ldr));
            chk("b_busy", int'(bus_b.busy), int'(mb.busy));
            chk("b_phase_pulse", int'(bus_b.phase_pulse), int'(mb.pulse));
            chk("b_cycles", int'(bus_b.cycles), mb.cyc);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic run_len(input logic lvl, output int n);
        n = 0;
        while (bus_a.ldr_out == lvl && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        int         len;
        int         npulse;
        logic [19:0] pat;
        logic [19:0] exp_pat;
        exp_pat = 20'b11111000001111100000;

        bus_a.en = 1'b1; bus_a.mode = 2'd0; bus_a.manual_level = 1'b1;
        bus_a.start = 1'b0; bus_a.stop = 1'b0;
        bus_b.en = 1'b1; bus_b.mode = 2'd0; bus_b.manual_level = 1'b0;
        bus_b.start = 1'b0; bus_b.stop = 1'b0;

        // 1. reset and manual level
        step(3);
        chk("rst_ldr_out", int'(bus_a.ldr_out), 0);
        chk("rst_busy", int'(bus_a.busy), 0);
        chk("rst_pulse", int'(bus_a.phase_pulse), 0);
        chk("rst_cycles", int'(bus_a.cycles), 0);
        rst = 1'b0;
        chk("rel_ldr_out_now", int'(bus_a.ldr_out), 0);
        step(1);
        chk("rel_ldr_out_next", int'(bus_a.ldr_out), 1);

        // 2. cycle timing: 15 clk day, 10 clk night
        bus_a.mode = 2'd1; bus_a.start = 1'b1;
        step(1);
        bus_a.start = 1'b0;
        run_len(1'b1, len);
        chk("cyc_day_len", len, 15);
        chk("cyc_pulse_d2n", int'(bus_a.phase_pulse), 1);
        run_len(1'b0, len);
        chk("cyc_night_len", len, 10);
        chk("cyc_pulse_n2d", int'(bus_a.phase_pulse), 1);
        chk("cyc_count_1", int'(bus_a.cycles), 1);
        step(50);
        chk("cyc_count_3", int'(bus_a.cycles), 3);
        bus_a.stop = 1'b1;
        step(1);
        bus_a.stop = 1'b0;

        // 4. stop 7 clk into the second day
        bus_a.start = 1'b1;
        step(1);
        bus_a.start = 1'b0;
        step(32);
        chk("stop_pre_ldr", int'(bus_a.ldr_out), 1);
        bus_a.manual_level = 1'b0; bus_a.stop = 1'b1;
        step(1);
        bus_a.stop = 1'b0;
        chk("stop_ldr", int'(bus_a.ldr_out), 0);
        chk("stop_busy", int'(bus_a.busy), 0);
        chk("stop_pulse", int'(bus_a.phase_pulse), 0);
        chk("stop_cycles", int'(bus_a.cycles), 1);

        // 5. enable freeze two clk into night
        bus_a.start = 1'b1;
        step(1);
        bus_a.start = 1'b0;
        step(17);
        bus_a.en = 1'b0; bus_a.start = 1'b1; bus_a.stop = 1'b1;
        step(3);
        chk("frz_ldr", int'(bus_a.ldr_out), 0);
        chk("frz_busy", int'(bus_a.busy), 1);
        bus_a.start = 1'b0; bus_a.stop = 1'b0;
        step(9);
        bus_a.en = 1'b1;
        run_len(1'b0, len);
        chk("frz_night_rest", len, 8);
        chk("frz_cycles", int'(bus_a.cycles), 1);
        bus_a.stop = 1'b1;
        step(1);
        bus_a.stop = 1'b0;

        // 3. burst pattern
        bus_a.manual_level = 1'b1; bus_a.mode = 2'd2; bus_a.start = 1'b1;
        step(1);
        bus_a.start = 1'b0;
        pat = 20'd0; npulse = 0;
        for (int i = 0; i < 21; i++) begin
            if (i < 20) pat = {pat[18:0], bus_a.ldr_out};
            npulse += int'(bus_a.phase_pulse);
            if (i < 20) step(1);
        end
        chk("burst_pattern", int'(pat), int'(exp_pat));
        chk("burst_pulses", npulse, 4);
        chk("burst_end_busy", int'(bus_a.busy), 0);
        chk("burst_end_ldr", int'(bus_a.ldr_out), 1);

        // 6. corner cases
        bus_a.mode = 2'd1; bus_a.start = 1'b1; bus_a.stop = 1'b1;
        step(1);
        bus_a.start = 1'b0; bus_a.stop = 1'b0;
        chk("ss_idle_busy", int'(bus_a.busy), 0);
        bus_a.mode = 2'd2; bus_a.start = 1'b1;
        step(1);
        bus_a.start = 1'b0;
        step(3);
        bus_a.mode = 2'd1; bus_a.start = 1'b1;
        step(1);
        bus_a.start = 1'b0;
        chk("busy_start_busy", int'(bus_a.busy), 1);
        chk("busy_start_cycles", int'(bus_a.cycles), 1);
        step(3);
        chk("burst_lo_ldr", int'(bus_a.ldr_out), 0);
        #1 rst = 1'b1;
        #1;
        chk("arst_ldr", int'(bus_a.ldr_out), 0);
        chk("arst_busy", int'(bus_a.busy), 0);
        chk("arst_pulse", int'(bus_a.phase_pulse), 0);
        chk("arst_cycles", int'(bus_a.cycles), 0);
        step(2);
        rst = 1'b0;

        // cycles saturation on the short-phase instance
        bus_b.mode = 2'd1; bus_b.start = 1'b1;
        step(1);
        bus_b.start = 1'b0;
        step(2549);
        chk("sat_cycles_254", int'(bus_b.cycles), 254);
        step(51);
        chk("sat_cycles_255", int'(bus_b.cycles), 255);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
